// File: rtl/axis_width_conv_wide_narrow.sv
// axis_width_conv_wide_narrow
//
// Splits each M-bit input word into R = M/N consecutive N-bit output slices.
// The most-significant slice is sent first. Both sides use a tnext/tvalid/tfirst
// pop protocol. The upstream source is an FWFT FIFO, and s_axis_tnext drives
// that FIFO's read enable.
//
// Optional feature macro: AXIS_WIDTH_CONV_TLAST_EN
//   When defined, the block adds the output m_axis_tlast. It is high on the
//   final slice of each wide word.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset (0 = in reset)
//   s_axis_tnext   pop strobe to the source; a word is consumed whenever it is 1
//   s_axis_tdata   wide input word (M bits)
//   s_axis_tfirst  frame-start marker of the input word
//   s_axis_tvalid  input word present (FWFT)
//   m_axis_tnext   consumer pop; a slice is consumed on m_axis_tvalid & m_axis_tnext
//   m_axis_tdata   current narrow slice (N bits), 0 when empty
//   m_axis_tfirst  frame-start marker, set only on slice 0 of a tfirst word
//   m_axis_tvalid  slice present
//   m_axis_tlast   (macro only) final slice of the current wide word
module axis_width_conv_wide_narrow #(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         s_axis_tnext,
  input  logic [M-1:0] s_axis_tdata,
  input  logic         s_axis_tfirst,
  input  logic         s_axis_tvalid,
  input  logic         m_axis_tnext,
  output logic [N-1:0] m_axis_tdata,
  output logic         m_axis_tfirst,
  output logic         m_axis_tvalid
`ifdef AXIS_WIDTH_CONV_TLAST_EN
  ,
  output logic         m_axis_tlast
`endif
);

  localparam int R  = M / N;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  // Stop elaboration when the wide word cannot be cut into whole slices.
  if ((N < 1) || ((M % N) != 0)) begin : g_param_check
    $error("axis_width_conv_wide_narrow: M (%0d) must be a multiple of N (%0d)", M, N);
  end

  logic [M-1:0]  hold;
  logic          hfirst;
  logic [IW-1:0] idx;
  logic          full;

  logic acc_out;
  logic last;

  // Handshake terms. The source is popped when the holding register is empty.
  // It is also popped in the same cycle that the last slice leaves, which gives
  // back-to-back words with no bubble. This creates a deliberate combinational
  // path from m_axis_tnext to s_axis_tnext. The pop is gated with s_axis_tvalid
  // because the source FIFO has no underflow protection. It is also gated with
  // rst so that nothing is popped while the block is held in reset.
  always_comb begin
    acc_out      = full & m_axis_tnext;
    last         = (idx == IW'(R - 1));
    s_axis_tnext = rst & s_axis_tvalid & (~full | (acc_out & last));
  end

  // Holding register and slice index. A load has priority over the drain, so a
  // word popped while the last slice leaves replaces the old word directly.
  // The register is cleared on drain so that the data output reads 0 when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold   <= '0;
      hfirst <= 1'b0;
      idx    <= '0;
      full   <= 1'b0;
    end else if (s_axis_tnext) begin
      hold   <= s_axis_tdata;
      hfirst <= s_axis_tfirst;
      idx    <= '0;
      full   <= 1'b1;
    end else if (acc_out && !last) begin
      idx <= idx + IW'(1);
    end else if (acc_out && last) begin
      hold   <= '0;
      hfirst <= 1'b0;
      idx    <= '0;
      full   <= 1'b0;
    end
  end

  // Slice selection works MSB-first: index 0 takes the top N bits of hold.
  always_comb begin
    m_axis_tdata = '0;
    if (full) begin
      for (int i = 0; i < R; i++) begin
        if (idx == IW'(i)) begin
          m_axis_tdata = hold[M-1-i*N -: N];
        end
      end
    end
    m_axis_tvalid = full;
    m_axis_tfirst = full & hfirst & (idx == '0);
  end

`ifdef AXIS_WIDTH_CONV_TLAST_EN
  // Marks the final slice of the current wide word.
  always_comb begin
    m_axis_tlast = full & last;
  end
`endif

endmodule

// File: tb/tb_axis_width_conv_wide_narrow.sv
// Testbench for axis_width_conv_wide_narrow.
//
// The main instance has N=4 and M=8. It is driven from a model of an FWFT FIFO.
// Each popped word pushes its expected slices into a scoreboard. Every slice
// the DUT hands out is popped from the scoreboard and compared.
//
// A second instance has N=M=8, and a third has N=2, M=8. Both are driven with
// short directed sequences.
module tb_axis_width_conv_wide_narrow;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Main instance signals (N=4, M=8).
  logic       sNext, sFirst, sValid, mNext, mFirst, mValid;
  logic [7:0] sData;
  logic [3:0] mData;

  // Pass-through instance signals (N=8, M=8).
  logic       s1Next, s1First, s1Valid, m1Next, m1First, m1Valid;
  logic [7:0] s1Data, m1Data;

  // Quarter-slice instance signals (N=2, M=8).
  logic       s2Next, s2First, s2Valid, m2Next, m2First, m2Valid;
  logic [7:0] s2Data;
  logic [1:0] m2Data;

`ifdef AXIS_WIDTH_CONV_TLAST_EN
  logic mLast, m1Last, m2Last;
`endif

  axis_width_conv_wide_narrow #(.N(4), .M(8)) u0 (
    .clk(clk), .rst(rst),
    .s_axis_tnext(sNext), .s_axis_tdata(sData), .s_axis_tfirst(sFirst), .s_axis_tvalid(sValid),
    .m_axis_tnext(mNext), .m_axis_tdata(mData), .m_axis_tfirst(mFirst), .m_axis_tvalid(mValid)
`ifdef AXIS_WIDTH_CONV_TLAST_EN
    , .m_axis_tlast(mLast)
`endif
  );

  axis_width_conv_wide_narrow #(.N(8), .M(8)) u1 (
    .clk(clk), .rst(rst),
    .s_axis_tnext(s1Next), .s_axis_tdata(s1Data), .s_axis_tfirst(s1First), .s_axis_tvalid(s1Valid),
    .m_axis_tnext(m1Next), .m_axis_tdata(m1Data), .m_axis_tfirst(m1First), .m_axis_tvalid(m1Valid)
`ifdef AXIS_WIDTH_CONV_TLAST_EN
    , .m_axis_tlast(m1Last)
`endif
  );

  axis_width_conv_wide_narrow #(.N(2), .M(8)) u2 (
    .clk(clk), .rst(rst),
    .s_axis_tnext(s2Next), .s_axis_tdata(s2Data), .s_axis_tfirst(s2First), .s_axis_tvalid(s2Valid),
    .m_axis_tnext(m2Next), .m_axis_tdata(m2Data), .m_axis_tfirst(m2First), .m_axis_tvalid(m2Valid)
`ifdef AXIS_WIDTH_CONV_TLAST_EN
    , .m_axis_tlast(m2Last)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int underflows = 0;
  int popCount, popCyc, firstValidCyc, outCount, firstOutCyc, lastOutCyc;

  // Source FIFO contents are stored as {tfirst, data}.
  // Scoreboard entries are stored as {tfirst, slice}.
  logic [8:0] srcQ[$];
  logic [4:0] sbQ[$];
  bit srcEn = 1'b1;
  bit consRdy = 1'b1;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one cycle of the main instance. Inputs are driven on the falling edge,
  // outputs are sampled 1ns later, and the FIFO and scoreboard are then updated
  // to mirror what the coming rising edge will do.
  task automatic applyStimulus();
    logic [4:0] e;
    logic [8:0] w;
    @(negedge clk);
    sValid = srcEn && (srcQ.size() > 0);
    {sFirst, sData} = (srcQ.size() > 0) ? srcQ[0] : 9'h0;
    mNext = consRdy;
    #1;
    cyc++;
    if (sNext && !sValid) underflows++;
    if (mValid && firstValidCyc < 0) firstValidCyc = cyc;
    if (mValid && mNext) begin
      outCount++;
      if (firstOutCyc < 0) firstOutCyc = cyc;
      lastOutCyc = cyc;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_slice", {27'h0, mFirst, mData}, 32'hFFFF_FFFF);
      end else begin
        e = sbQ.pop_front();
        checkOutput("slice_data", {28'h0, mData}, {28'h0, e[3:0]});
        checkOutput("slice_first", {31'h0, mFirst}, {31'h0, e[4]});
      end
    end
    if (sNext && srcQ.size() > 0) begin
      w = srcQ.pop_front();
      popCount++;
      popCyc = cyc;
      for (int i = 0; i < 2; i++) begin
        sbQ.push_back({(i == 0) ? w[8] : 1'b0, w[7-4*i -: 4]});
      end
    end
  endtask

  task automatic resetMeasures();
    popCount = 0;
    popCyc = -1;
    firstValidCyc = -1;
    outCount = 0;
    firstOutCyc = -1;
    lastOutCyc = -1;
  endtask

  task automatic runUntilDrained(input int maxCycles, input string tag);
    int n = 0;
    while ((srcQ.size() > 0 || sbQ.size() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, srcQ.size() + sbQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    sValid = 1'b1; sData = 8'hFF; sFirst = 1'b1; mNext = 1'b1;
    s1Valid = 1'b0; s1Data = 8'h00; s1First = 1'b0; m1Next = 1'b1;
    s2Valid = 1'b0; s2Data = 8'h00; s2First = 1'b0; m2Next = 1'b1;
    resetMeasures();

    // While in reset: outputs are zero and no pop happens, even with the source valid.
    #2;
    checkOutput("rst_tvalid", {31'h0, mValid}, 0);
    checkOutput("rst_tdata", {28'h0, mData}, 0);
    checkOutput("rst_tfirst", {31'h0, mFirst}, 0);
    checkOutput("rst_tnext", {31'h0, sNext}, 0);
    @(negedge clk);
    sValid = 1'b0;
    rst = 1'b1;

    // Single word 0xA5: slice A then slice 5, with exactly one pop and latency 1.
    resetMeasures();
    srcQ.push_back({1'b1, 8'hA5});
    runUntilDrained(20, "t1_drain");
    repeat (2) applyStimulus();
    checkOutput("t1_pops", popCount, 1);
    checkOutput("t1_latency", firstValidCyc - popCyc, 1);
    checkOutput("t1_slices", outCount, 2);

    // Random stream with the consumer always ready: one slice per cycle, no bubbles.
    resetMeasures();
    for (int i = 0; i < 1024; i++) begin
      srcQ.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
    end
    runUntilDrained(3000, "t2_drain");
    checkOutput("t2_count", outCount, 2048);
    checkOutput("t2_no_bubbles", lastOutCyc - firstOutCyc + 1, 2048);

    // Backpressure: stall on slice 3 of 0x3C, then release.
    resetMeasures();
    consRdy = 1'b0;
    srcQ.push_back({1'b0, 8'h3C});
    srcQ.push_back({1'b0, 8'h91});
    applyStimulus();
    repeat (5) begin
      applyStimulus();
      checkOutput("t3_hold_data", {28'h0, mData}, 32'h3);
      checkOutput("t3_hold_valid", {31'h0, mValid}, 1);
      checkOutput("t3_no_pop", {31'h0, sNext}, 0);
    end
    consRdy = 1'b1;
    runUntilDrained(20, "t3_drain");
    checkOutput("t3_pops", popCount, 2);

    // Source runs empty with the consumer ready.
    resetMeasures();
    srcQ.push_back({1'b0, 8'h5A});
    repeat (20) applyStimulus();
    checkOutput("t4_valid_low", {31'h0, mValid}, 0);
    checkOutput("t4_count", outCount, 2);
    checkOutput("t4_pops", popCount, 1);

    // Reset arrives mid-word, after slice A: the remaining slice is dropped.
    resetMeasures();
    srcQ.push_back({1'b1, 8'hA5});
    applyStimulus();
    applyStimulus();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_async_valid", {31'h0, mValid}, 0);
    checkOutput("t5_async_data", {28'h0, mData}, 0);
    sbQ.delete();
    @(negedge clk);
    rst = 1'b1;
    resetMeasures();
    srcQ.push_back({1'b0, 8'h7E});
    runUntilDrained(20, "t5_drain");
    checkOutput("t5_count", outCount, 2);

    // N=2, M=8: word 0xE4 comes out as 3,2,1,0.
    @(negedge clk);
    s2Valid = 1'b1; s2Data = 8'hE4; s2First = 1'b1;
    #1;
    checkOutput("w2_pop", {31'h0, s2Next}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s2Valid = 1'b0;
      #1;
      checkOutput("w2_data", {30'h0, m2Data}, 32'(3 - i));
      checkOutput("w2_first", {31'h0, m2First}, (i == 0) ? 32'd1 : 32'd0);
`ifdef AXIS_WIDTH_CONV_TLAST_EN
      checkOutput("w2_last", {31'h0, m2Last}, (i == 3) ? 32'd1 : 32'd0);
`endif
    end
    @(negedge clk);
    #1;
    checkOutput("w2_idle", {31'h0, m2Valid}, 0);

    // N=M=8: back-to-back words at full throughput.
    @(negedge clk);
    s1Valid = 1'b1; s1Data = 8'h5A; s1First = 1'b1;
    #1;
    checkOutput("w1_pop0", {31'h0, s1Next}, 1);
    @(negedge clk);
    s1Data = 8'hC3; s1First = 1'b0;
    #1;
    checkOutput("w1_data0", {24'h0, m1Data}, 32'h5A);
    checkOutput("w1_first0", {31'h0, m1First}, 1);
    checkOutput("w1_pop1", {31'h0, s1Next}, 1);
`ifdef AXIS_WIDTH_CONV_TLAST_EN
    checkOutput("w1_last0", {31'h0, m1Last}, 1);
`endif
    @(negedge clk);
    s1Valid = 1'b0;
    #1;
    checkOutput("w1_data1", {24'h0, m1Data}, 32'hC3);
    checkOutput("w1_first1", {31'h0, m1First}, 0);
`ifdef AXIS_WIDTH_CONV_TLAST_EN
    checkOutput("w1_last1", {31'h0, m1Last}, 1);
`endif
    @(negedge clk);
    #1;
    checkOutput("w1_idle", {31'h0, m1Valid}, 0);

    checkOutput("no_underflow", underflows, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_width_conv_wide_narrow.md
Name: axis_width_conv_wide_narrow

Overview:
Splits each M-bit stream word into M/N consecutive N-bit words, most-significant slice first. It is the inverse of the narrow-to-wide converter and uses the same tnext/tvalid/tfirst stream protocol. It sits downstream of a wide datapath stage and feeds narrow consumers such as serializers or narrow FIFOs. The upstream source is typically an FWFT FIFO whose rd_en is driven by s_axis_tnext.

Parameters:
N, 4, output (narrow) data width in bits; N >= 1
M, 8, input (wide) data width in bits; M must be an integer multiple of N, otherwise elaboration fails with $error
R (localparam), M/N, number of slices per wide word

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = in reset)
s_axis_tnext  output  1  pop strobe to source; word consumed in any cycle where this is 1
s_axis_tdata  input  M  wide input word
s_axis_tfirst  input  1  frame-start marker of input word
s_axis_tvalid  input  1  input word present (FWFT: data valid without a pop)
m_axis_tnext  input  1  consumer pop; slice consumed when m_axis_tvalid & m_axis_tnext
m_axis_tdata  output  N  current narrow slice
m_axis_tfirst  output  1  frame-start marker, only on slice 0 of a word whose input tfirst was 1
m_axis_tvalid  output  1  slice present

Behaviour:
- State registers:
  - hold[M-1:0]: captured word
  - hfirst: captured tfirst
  - idx: 0..R-1, $clog2(R) bits, minimum 1 bit
  - full: 1 = hold contains unsent slices
- Reset (rst=0, asynchronous): full=0, idx=0, hold=0, hfirst=0.
  - Outputs during reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tfirst=0.
  - s_axis_tnext is forced to 0 combinationally while rst=0.
- Acceptance terms:
  - acc_out = full & m_axis_tnext
  - last = (idx == R-1)
- Pop (combinational): s_axis_tnext = rst & s_axis_tvalid & (~full | (acc_out & last)).
  - Never asserted when s_axis_tvalid=0. This rule is mandatory because the source is a FIFO with no underflow protection.
  - The combinational path m_axis_tnext -> s_axis_tnext is intended.
- Load: when s_axis_tnext=1, on the next edge: hold <= s_axis_tdata, hfirst <= s_axis_tfirst, idx <= 0, full <= 1.
- Advance: when acc_out & ~last, idx <= idx+1.
- Drain: when acc_out & last & ~s_axis_tnext, full <= 0 and idx <= 0.
- Outputs (all combinational from registers):
  - m_axis_tvalid = full
  - m_axis_tdata = hold[M-1-idx*N -: N]
  - m_axis_tfirst = full & hfirst & (idx == 0)
  - m_axis_tdata reads 0 when full=0; hold is cleared on drain.
- Latency: word popped in cycle k presents slice 0 in cycle k+1.
- Throughput: with m_axis_tnext held at 1 and the source never empty, output is one slice per cycle with no bubbles. The last slice and the next pop occur in the same cycle.
- Backpressure: while m_axis_tnext=0, all state holds and s_axis_tnext=0 whenever full=1.
- m_axis_tnext=1 with m_axis_tvalid=0 is ignored.
- R=1 (M==N): behaves as a single-entry pipeline register with full throughput; idx is constant 0.
- Reset mid-word: the remaining slices are discarded. After release, the block restarts empty and the first new word begins at slice 0.

Optional Feature:
Macro: AXIS_WIDTH_CONV_TLAST_EN
- Defined: adds output port m_axis_tlast (1 bit) = full & (idx == R-1), marking the final slice of each wide word. Its reset value is 0.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- N=4, M=8: single word 0xA5 with tfirst=1, consumer always ready -> outputs A (tfirst=1) in cycle k+1, then 5 (tfirst=0) in cycle k+2. s_axis_tnext pulses exactly once.
- N=4, M=8: 1024 random words from FIFO with m_axis_tnext = m_axis_tvalid -> 2048 slices, one per cycle after the first, matching an MSB-first scoreboard including tfirst.
- Backpressure: m_axis_tnext held 0 for 5 cycles after the first slice of 0x3C -> data stays 3 and s_axis_tnext stays 0. After release: C, then the next word follows.
- Source empty (s_axis_tvalid=0 for 20 cycles) with the consumer ready -> s_axis_tnext never 1 and m_axis_tvalid drops after the last slice.
- Reset mid-word: rst=0 asynchronously after slice A of 0xA5 -> m_axis_tvalid=0 immediately and 5 is never emitted. After release, the next word 0x7E yields 7, then E.
- N=M=8 and macro defined with N=2, M=8: word 0xE4 -> outputs 3,2,1,0 with m_axis_tlast=1 only on 0. For N=M, m_axis_tlast=1 on every word.
